// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and load/store.
// Round-robin tie-break, grant FSM with timeout watchdog and sticky error.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_MEM,
        DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_mem;
    logic [15:0] cnt;
    logic        pick_mem;
    logic        pick_if;
    logic        to_hit;

    // MEM wins unless IF is also waiting and MEM had the previous grant
    always_comb begin
        pick_mem = mem_req & ~(if_req & last_mem);
        pick_if  = if_req & ~pick_mem;
        to_hit   = (cnt == TO_LAST);
    end

    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = mem_req & ~mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_mem  <= 1'b0;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= 4'b0000;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_mem) begin
                        state     <= GNT_MEM;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_sel   <= mem_sel;
                        last_mem  <= 1'b1;
                        cnt       <= '0;
                    end else if (pick_if) begin
                        state     <= GNT_IF;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_sel   <= 4'b1111;
                        last_mem  <= 1'b0;
                        cnt       <= '0;
                    end
                end
                GNT_IF, GNT_MEM: begin
                    // a real ack on the timeout cycle takes precedence
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (state == GNT_IF) begin
                            if_rdata <= bus_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            if (!bus_we)
                                mem_rdata <= bus_rdata;
                            mem_ack <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (state == GNT_IF) begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                        end else begin
                            mem_rdata <= '0;
                            mem_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, latency, store hold,
// timeout, reset mid-transfer and ack-on-timeout-cycle precedence.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_req, bus_we;
    logic [3:0]  bus_sel;
    logic        stallreq_if, stallreq_mem, bus_err;

    logic [31:0] if_rdata4, mem_rdata4, bus_addr4, bus_wdata4;
    logic        if_ack4, mem_ack4, bus_req4, bus_we4;
    logic [3:0]  bus_sel4;
    logic        stallreq_if4, stallreq_mem4, bus_err4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .bus_err(bus_err)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata4), .if_ack(if_ack4),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata4), .mem_ack(mem_ack4),
        .bus_req(bus_req4), .bus_we(bus_we4), .bus_addr(bus_addr4),
        .bus_wdata(bus_wdata4), .bus_sel(bus_sel4),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_if(stallreq_if4), .stallreq_mem(stallreq_mem4),
        .bus_err(bus_err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        mem_req = 0; mem_we = 0; mem_addr = '0;
        mem_wdata = '0; mem_sel = '0;
        bus_rdata = '0; bus_ack = 0;
        #2;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single IF read, minimum latency
        if_req = 1; if_addr = 32'h0000_0040;
        #1 chk("if1_stall_n", {31'd0, stallreq_if}, 32'd1);
        tick();
        chk("if1_bus_req", {31'd0, bus_req}, 32'd1);
        chk("if1_bus_addr", bus_addr, 32'h40);
        chk("if1_bus_we", {31'd0, bus_we}, 32'd0);
        chk("if1_bus_sel", {28'd0, bus_sel}, 32'hF);
        chk("if1_stall_n1", {31'd0, stallreq_if}, 32'd1);
        bus_ack = 1; bus_rdata = 32'h8C22_0004;
        tick();
        chk("if1_ack", {31'd0, if_ack}, 32'd1);
        chk("if1_rdata", if_rdata, 32'h8C22_0004);
        chk("if1_bus_drop", {31'd0, bus_req}, 32'd0);
        chk("if1_stall_done", {31'd0, stallreq_if}, 32'd0);
        bus_ack = 0; if_req = 0;
        tick();
        chk("if1_ack_pulse", {31'd0, if_ack}, 32'd0);

        // both request, last grant IF -> MEM first, then IF
        if_req = 1; if_addr = 32'h44;
        mem_req = 1; mem_we = 0; mem_addr = 32'h100; mem_sel = 4'hF;
        tick();
        chk("arb1_mem_first", bus_addr, 32'h100);
        chk("arb1_we", {31'd0, bus_we}, 32'd0);
        chk("arb1_stall_if", {31'd0, stallreq_if}, 32'd1);
        bus_ack = 1; bus_rdata = 32'h1111_1111;
        tick();
        chk("arb1_mem_ack", {31'd0, mem_ack}, 32'd1);
        chk("arb1_mem_rdata", mem_rdata, 32'h1111_1111);
        chk("arb1_if_noack", {31'd0, if_ack}, 32'd0);
        bus_ack = 0; mem_req = 0;
        tick();
        chk("arb1_idle_gap", {31'd0, bus_req}, 32'd0);
        tick();
        chk("arb1_if_next", bus_addr, 32'h44);
        chk("arb1_if_sel", {28'd0, bus_sel}, 32'hF);
        bus_ack = 1; bus_rdata = 32'h2222_2222;
        tick();
        chk("arb1_if_ack", {31'd0, if_ack}, 32'd1);
        chk("arb1_if_rdata", if_rdata, 32'h2222_2222);
        bus_ack = 0; if_req = 0;
        tick();

        // store with three wait states
        mem_req = 1; mem_we = 1; mem_addr = 32'h200;
        mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        chk("st_we", {31'd0, bus_we}, 32'd1);
        chk("st_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("st_sel", {28'd0, bus_sel}, 32'h3);
        for (int i = 0; i < 4; i++) begin
            chk("st_hold_req", {31'd0, bus_req}, 32'd1);
            chk("st_hold_addr", bus_addr, 32'h200);
            chk("st_no_ack", {31'd0, mem_ack}, 32'd0);
            mem_addr = 32'h0;
            if (i == 3) bus_ack = 1;
            if (i < 3) tick();
        end
        tick();
        chk("st_ack", {31'd0, mem_ack}, 32'd1);
        chk("st_rdata_keep", mem_rdata, 32'h1111_1111);
        chk("st_bus_drop", {31'd0, bus_req}, 32'd0);
        bus_ack = 0; mem_req = 0; mem_we = 0;
        tick();
        chk("st_ack_pulse", {31'd0, mem_ack}, 32'd0);

        // both request, last grant MEM -> IF first
        if_req = 1; if_addr = 32'h48;
        mem_req = 1; mem_addr = 32'h104; mem_sel = 4'hF;
        tick();
        chk("arb2_if_first", bus_addr, 32'h48);
        bus_ack = 1; bus_rdata = 32'h3333_3333;
        tick();
        chk("arb2_if_ack", {31'd0, if_ack}, 32'd1);
        chk("arb2_if_rdata", if_rdata, 32'h3333_3333);
        bus_ack = 0; if_req = 0;
        tick();
        chk("arb2_mem_wait", {31'd0, mem_ack}, 32'd0);
        tick();
        chk("arb2_mem_next", bus_addr, 32'h104);
        bus_ack = 1; bus_rdata = 32'h4444_4444;
        tick();
        chk("arb2_mem_ack", {31'd0, mem_ack}, 32'd1);
        chk("arb2_mem_rdata", mem_rdata, 32'h4444_4444);
        bus_ack = 0; mem_req = 0;
        tick();

        // timeout (TIMEOUT=8), bus never acks
        if_req = 1; if_addr = 32'h80;
        tick();
        chk("to_first_gnt", {31'd0, bus_req}, 32'd1);
        repeat (7) tick();
        chk("to_eighth_gnt", {31'd0, bus_req}, 32'd1);
        chk("to_no_err_yet", {31'd0, bus_err}, 32'd0);
        tick();
        chk("to_bus_drop", {31'd0, bus_req}, 32'd0);
        chk("to_if_ack", {31'd0, if_ack}, 32'd1);
        chk("to_if_rdata", if_rdata, 32'd0);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        if_req = 0; bus_ack = 1; bus_rdata = 32'h7777_7777;
        tick();
        chk("to_stray_ack", if_rdata, 32'd0);
        chk("to_ack_pulse", {31'd0, if_ack}, 32'd0);
        bus_ack = 0;
        repeat (3) tick();
        chk("to_err_sticky", {31'd0, bus_err}, 32'd1);

        // reset during GNT_MEM
        mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_sel = 4'hF;
        tick();
        chk("rm_gnt", {31'd0, bus_req}, 32'd1);
        rst = 1;
        #1;
        chk("rm_bus_release", {31'd0, bus_req}, 32'd0);
        chk("rm_no_ack", {31'd0, mem_ack}, 32'd0);
        chk("rm_err_clear", {31'd0, bus_err}, 32'd0);
        chk("rm_rdata_clear", mem_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        chk("rm_no_ack2", {31'd0, mem_ack}, 32'd0);
        tick();
        chk("rm_regrant", bus_addr, 32'h300);
        chk("rm_regrant_req", {31'd0, bus_req}, 32'd1);
        bus_ack = 1; bus_rdata = 32'h5555_5555;
        tick();
        chk("rm_ack", {31'd0, mem_ack}, 32'd1);
        chk("rm_rdata", mem_rdata, 32'h5555_5555);
        bus_ack = 0; mem_req = 0;
        tick();

        // TIMEOUT=4, ack on fourth GNT cycle; requester drops req early
        if_req = 1; if_addr = 32'h90;
        tick();
        tick();
        if_req = 0;
        tick();
        tick();
        chk("late_still_gnt", {31'd0, bus_req4}, 32'd1);
        bus_ack = 1; bus_rdata = 32'h6666_6666;
        tick();
        chk("late_ack", {31'd0, if_ack4}, 32'd1);
        chk("late_rdata", if_rdata4, 32'h6666_6666);
        chk("late_no_err", {31'd0, bus_err4}, 32'd0);
        bus_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (IF requester) and load/store (MEM requester, driven by LW/SW).
- Sequences each transfer with a grant FSM and a timeout watchdog.
- Raises per-requester stall requests to the pipeline controller, alongside the decode-stage load-use stallreq.
- Sits between the pipeline stages and the external SRAM/bus port.

Parameters:
- ADDR_W, 32, address width (matches instruction/data address bus).
- DATA_W, 32, data width (matches register bus).
- TIMEOUT, 255, max cycles in BUSY without bus_ack before abort (1..2^16-1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF read request, held until if_ack
- if_addr  in  ADDR_W  IF read address
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse to IF
- mem_req  in  1  MEM request, held until mem_ack
- mem_we  in  1  1=store (SW), 0=load (LW)
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_sel  in  4  byte enables
- mem_rdata  out  DATA_W  load data, valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse to MEM
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_sel  out  4  bus byte enables
- bus_rdata  in  DATA_W  bus read data, valid with bus_ack
- bus_ack  in  1  bus completion, sampled only while bus_req=1
- stallreq_if  out  1  IF stall request
- stallreq_mem  out  1  MEM stall request
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values (async, immediate):
  - state=IDLE.
  - bus_req, bus_we, if_ack, mem_ack, bus_err = 0.
  - bus_addr, bus_wdata, if_rdata, mem_rdata = 0; bus_sel=4'b0000.
  - last_grant=IF; timeout counter=0.
- FSM states:
  - IDLE -> GNT_IF or GNT_MEM on the cycle a request is sampled.
  - GNT_x -> DONE on bus_ack=1, or on timeout.
  - DONE -> IDLE unconditionally; one cycle, during which the ack pulse is high.
- Arbitration in IDLE:
  - MEM wins by default.
  - If both requests are pending and last_grant=MEM, IF wins. This prevents fetch starvation under back-to-back loads/stores.
  - last_grant updates on each grant.
- Grant:
  - Registers the address/we/wdata/sel of the winner into the bus outputs, bus_req=1 from the next cycle.
  - An IF grant forces bus_we=0 and bus_sel=4'b1111.
  - Bus outputs are held stable until bus_ack; bus_req drops in DONE.
- Completion:
  - On bus_ack, bus_rdata is captured into the granted requester's rdata register.
  - In DONE, that requester's ack=1 for exactly one cycle.
  - rdata holds its value until the next completion for the same requester.
  - MEM store completion returns mem_rdata unchanged.
- Latency: request at cycle N, bus_req at N+1, earliest bus_ack at N+1, ack at N+2. Minimum 2 cycles, plus one IDLE cycle between transfers.
- Stall outputs (combinational):
  - stallreq_if = if_req & ~if_ack.
  - stallreq_mem = mem_req & ~mem_ack.
- Timeout:
  - A 16-bit counter clears on grant and increments each GNT cycle without bus_ack.
  - At count==TIMEOUT-1 without ack: bus_req drops, state moves to DONE, requester ack pulses with rdata=0, and bus_err is set.
  - bus_err clears only by rst.
- Boundary conditions:
  - A requester dropping req mid-transfer does not abort it; the bus cycle completes and the ack still pulses.
  - A request arriving during GNT/DONE waits in IDLE.
  - bus_ack outside GNT is ignored.
  - bus_ack on the same cycle as timeout: the ack wins, and neither bus_err nor the zero data applies.
  - rst mid-transfer: the bus is released immediately (bus_req=0), no ack is issued, and the requester re-requests after reset.

Test Plan:
- Single IF read: if_req=1, if_addr=0x0000_0040, bus_ack one cycle after bus_req, bus_rdata=0x8C22_0004 -> bus_addr=0x40, bus_we=0, bus_sel=F; if_ack pulses at cycle N+2 with if_rdata=0x8C22_0004; stallreq_if high cycles N..N+1.
- Simultaneous requests: if_req and mem_req (LW, addr 0x100) at the same cycle, last_grant=IF -> MEM served first; IF granted next. Then both again with last_grant=MEM -> IF served first.
- Store: mem_req=1, mem_we=1, addr 0x200, wdata=0xDEAD_BEEF, sel=0011, bus_ack after 3 wait cycles -> bus outputs held for 4 cycles; mem_ack one pulse; mem_rdata unchanged.
- Timeout with TIMEOUT=8: IF request, bus_ack never asserted -> bus_req drops after 8 GNT cycles; if_ack pulses with if_rdata=0; bus_err=1 stays high until rst.
- Reset mid-transfer: assert rst during GNT_MEM -> bus_req=0 the same cycle, no mem_ack; after release, state IDLE and a new MEM request completes normally.
- Late bus_ack on the timeout cycle (TIMEOUT=4, ack on the 4th cycle) -> normal completion with captured data; bus_err=0.
